// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line into the receiver, received word and status back out.
interface uart_rx_if #(
  parameter int unsigned DATA_W = 8
);
  logic              serial_in;
  logic [DATA_W-1:0] received_data;
  logic              data_is_valid;
  logic              rx_error;
  logic              o_busy;

  // Line driver / word consumer side
  modport master (
    output serial_in,
    input  received_data,
    input  data_is_valid,
    input  rx_error,
    input  o_busy
  );

  // Receiver side
  modport slave (
    input  serial_in,
    output received_data,
    output data_is_valid,
    output rx_error,
    output o_busy
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Start bit, INPUT_DATA_WIDTH data bits LSB first,
// optional parity bit, one stop bit. Mid-bit sampling from a phase counter,
// parity and framing checks, one-cycle valid/error pulses.
// Optional feature: define UART_RX_MAJORITY_VOTE_EN to decide each bit by a
// 2-of-3 vote around mid-bit (all sample points move one cycle later).
module uart_rx #(
  parameter int unsigned INPUT_DATA_WIDTH = 8,
  parameter int unsigned PARITY_ENABLED   = 1,
  parameter int unsigned PARITY_TYPE      = 0,
  parameter int unsigned CLOCKS_PER_BIT   = 8
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave bus
);

  localparam int unsigned NUMBER_OF_BITS = INPUT_DATA_WIDTH + PARITY_ENABLED + 2;
  localparam int unsigned BIT_W          = $clog2(NUMBER_OF_BITS);
  localparam int unsigned PHASE_W        = $clog2(CLOCKS_PER_BIT);
  localparam int unsigned HALF           = CLOCKS_PER_BIT / 2;

  // phase_q holds the value before an edge; it is 0 during the cycle after
  // detection, so the edge where phase_q == HALF-1 lies HALF cycles after it.
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLOCKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [PHASE_W-1:0] PHASE_V0     = PHASE_W'(HALF - 2);
  localparam logic [PHASE_W-1:0] PHASE_V1     = PHASE_W'(HALF - 1);
  localparam logic [PHASE_W-1:0] PHASE_DECIDE = PHASE_W'(HALF);
`else
  localparam logic [PHASE_W-1:0] PHASE_DECIDE = PHASE_W'(HALF - 1);
`endif
  localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(INPUT_DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                      state_q, state_d;
  logic [2:0]                  sync_q, sync_d;
  logic [PHASE_W-1:0]          phase_q, phase_d;
  logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
  logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                        par_err_q, par_err_d;
  logic [INPUT_DATA_WIDTH-1:0] received_data_q, received_data_d;
  logic                        data_is_valid_q, data_is_valid_d;
  logic                        rx_error_q, rx_error_d;
  logic                        o_busy_q, o_busy_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0]                  vote_q, vote_d;
`endif

  logic                        serial_in_synced;
  logic                        sample_tick;
  logic                        bit_val;
  logic                        par_exp;
  logic [INPUT_DATA_WIDTH:0]   shift_in;

  assign serial_in_synced = sync_q[2];

  // Next-state, datapath and output pulses
  always_comb begin
    state_d         = state_q;
    sync_d          = {sync_q[1:0], bus.serial_in};
    phase_d         = phase_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    par_err_d       = par_err_q;
    received_data_d = received_data_q;
    data_is_valid_d = 1'b0;
    rx_error_d      = 1'b0;

    sample_tick = (state_q != S_IDLE) && (phase_q == PHASE_DECIDE);
`ifdef UART_RX_MAJORITY_VOTE_EN
    vote_d = vote_q;
    if (phase_q == PHASE_V0) vote_d[0] = serial_in_synced;
    if (phase_q == PHASE_V1) vote_d[1] = serial_in_synced;
    bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & serial_in_synced) |
              (vote_q[1] & serial_in_synced);
`else
    bit_val = serial_in_synced;
`endif
    par_exp  = (^shift_q) ^ 1'(PARITY_TYPE);
    shift_in = {bit_val, shift_q};

    if (state_q != S_IDLE) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        phase_d   = '0;
        bit_cnt_d = '0;
        if (!serial_in_synced) state_d = S_START;
      end
      S_START: begin
        if (sample_tick) begin
          if (bit_val) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            par_err_d = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          shift_d   = shift_in[INPUT_DATA_WIDTH:1];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_DATA_BIT) begin
            state_d = (PARITY_ENABLED != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (sample_tick) begin
          par_err_d = (bit_val != par_exp);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          received_data_d = shift_q;
          data_is_valid_d = 1'b1;
          rx_error_d      = par_err_q | ~bit_val;
          state_d         = bit_val ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        // Hold off until the line is released so a stuck-low line is one frame
        if (serial_in_synced) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    o_busy_d = (state_d != S_IDLE);
  end

  // State and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      sync_q          <= '1;
      phase_q         <= '0;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      received_data_q <= '0;
      data_is_valid_q <= 1'b0;
      rx_error_q      <= 1'b0;
      o_busy_q        <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q          <= '1;
`endif
    end else begin
      state_q         <= state_d;
      sync_q          <= sync_d;
      phase_q         <= phase_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      par_err_q       <= par_err_d;
      received_data_q <= received_data_d;
      data_is_valid_q <= data_is_valid_d;
      rx_error_q      <= rx_error_d;
      o_busy_q        <= o_busy_d;
`ifdef UART_RX_MAJORITY_VOTE_EN
      vote_q          <= vote_d;
`endif
    end
  end

  assign bus.received_data = received_data_q;
  assign bus.data_is_valid = data_is_valid_q;
  assign bus.rx_error      = rx_error_q;
  assign bus.o_busy        = o_busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone UART receiver that deserialises the frame format produced by the team's UART transmitter: start bit (0), `INPUT_DATA_WIDTH` data bits LSB first, an optional parity bit, and one stop bit (1). It synchronises the asynchronous `serial_in` line, samples each bit at mid-bit using an oversampling counter, and checks parity and framing. It presents each received word with a one-cycle valid pulse. It is the receive end of the serial link and is used alone or paired with the transmitter in loopback benches.

## Interface
- `INPUT_DATA_WIDTH`, 8, data bits per frame (1..16).
- `PARITY_ENABLED`, 1, 1 = parity bit present between data and stop; 0 = absent.
- `PARITY_TYPE`, 0, 0 = even (parity bit = ^data), 1 = odd (parity bit = ~^data).
- `CLOCKS_PER_BIT`, 8, clk cycles per bit; even, ≥4.

- `clk` input 1 — sole clock.
- `reset` input 1 — synchronous, active-high.
- `serial_in` input 1 — asynchronous line, idle high.
- `received_data` output `INPUT_DATA_WIDTH` — last completed word; holds until the next frame completes.
- `data_is_valid` output 1 — one-cycle pulse per completed frame.
- `rx_error` output 1 — one-cycle pulse coincident with `data_is_valid` on a parity or stop-bit error.
- `o_busy` output 1 — high in every state except IDLE.

## Operation
- Synchroniser: 3 flip-flops in series; all reset to 1. FSM sees only the third stage (`serial_in_synced`).
- Bit counter `bit_cnt`: `NUMBER_OF_BITS = INPUT_DATA_WIDTH + PARITY_ENABLED + 2`, width `$clog2(NUMBER_OF_BITS)`. Phase counter width `$clog2(CLOCKS_PER_BIT)`, wraps at `CLOCKS_PER_BIT-1`.
- States:
  - IDLE: while `serial_in_synced==0`, go to START and clear the phase counter. The edge on which this happens is the detection edge D.
  - START: sample at D+`CLOCKS_PER_BIT/2`. If the sample is 1, this is a false start: return to IDLE with no outputs. If 0, go to DATA.
  - DATA: sample every `CLOCKS_PER_BIT` cycles and shift right into the data register (first bit ends at bit 0). After `INPUT_DATA_WIDTH` samples, go to PARITY if `PARITY_ENABLED`, else to STOP.
  - PARITY: one sample, compared against parity computed over the shifted data per `PARITY_TYPE`.
  - STOP: one sample. On the sample edge, load `received_data`, pulse `data_is_valid`, and pulse `rx_error` = parity_mismatch | (stop==0). If stop==1, go to IDLE immediately; the remaining half-bit is not waited for. If stop==0, go to BREAK.
  - BREAK: wait for `serial_in_synced==1`, then go to IDLE. No outputs. Prevents retriggering on a held-low line.
- A word with an error is still presented on `received_data`, with `rx_error` set.
- Reset, including mid-frame: synchroniser set to 1, state IDLE, counters 0, `received_data`=0, `data_is_valid`=0, `rx_error`=0, `o_busy`=0. The partial frame is discarded.

## Timing
- Serial_in low first sampled at edge t0 → synchroniser output low after edge t0+2 → D = t0+3.
- Bit k (k=0 start … NUMBER_OF_BITS-1 stop) is sampled at edge D + `CLOCKS_PER_BIT/2` + k·`CLOCKS_PER_BIT`.
- `data_is_valid`/`rx_error` are registered at the stop-sample edge and are high for exactly the following cycle. With defaults: stop sampled at D+84, valid high in cycle D+85 = t0+88.
- Back-to-back frames: IDLE is re-entered one cycle after the stop sample, so a start bit beginning immediately after a full-length stop bit is detected.
- `o_busy` rises in the cycle after D and falls in the cycle after the stop sample, or after BREAK exits.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined: each bit value is the 2-of-3 majority of synced samples at phase `CLOCKS_PER_BIT/2-1`, `/2`, and `/2+1`. The decision is taken at phase `/2+1`, so every sample edge and output pulse in Timing shifts one cycle later. A false-start check also uses the majority.
- Undefined: single sample at phase `CLOCKS_PER_BIT/2`; timing exactly as stated above.

## Test plan
- Defaults, frame 0xA5 with even parity 0 and stop 1 → `received_data`=0xA5, `data_is_valid` high 1 cycle at t0+88, `rx_error`=0.
- Frame 0x3C with parity bit driven 1 → `received_data`=0x3C, `data_is_valid`=1 and `rx_error`=1 in the same cycle.
- Frame 0x00 with stop bit held 0 for 3 bit times → `rx_error`=1 pulse, `o_busy` stays high until the line returns high, no second frame is detected.
- `serial_in` low for 2 cycles then high → no `data_is_valid`, `o_busy` returns 0 at D+`CLOCKS_PER_BIT/2`+1.
- Two frames 0x55 and 0xAA back-to-back with zero idle gap → two valid pulses 88 cycles apart showing 0x55 then 0xAA, no error.
- `reset` asserted at D+40 mid-frame → all outputs 0 on the next cycle, state IDLE, next frame 0x81 received correctly.
